data_mem_bridge: RTL and testbench

- Sits directly downstream of the pipelined datapath's MEM stage and consumes its data-memory request outputs: address, write data, read/write enables and funct3 format.
- Converts each request into a word-aligned, byte-enabled access on a wait-stated req/ack memory bus.
- Returns load data aligned and sign- or zero-extended.
- Holds the pipeline with `busy` until the access completes.
- Flags misaligned or illegal accesses.

---
 rtl/mem_bridge_pkg.sv | 31 +++
 rtl/data_mem_bridge_load_aligner.sv | 36 +++
 rtl/data_mem_bridge.sv | 135 +++++++++++++
 tb/tb_data_mem_bridge.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: funct3 load/store formats,
// controller states and access legality helpers.
package mem_bridge_pkg;

  localparam logic [2:0] FMT_B  = 3'b000;
  localparam logic [2:0] FMT_H  = 3'b001;
  localparam logic [2:0] FMT_W  = 3'b010;
  localparam logic [2:0] FMT_BU = 3'b100;
  localparam logic [2:0] FMT_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  function automatic logic is_aligned(input logic [2:0] fmt, input logic [1:0] a);
    case (fmt)
      FMT_H, FMT_HU: return ~a[0];
      FMT_W:         return (a == 2'b00);
      default:       return 1'b1;
    endcase
  endfunction

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic is_legal_format(input logic [2:0] fmt, input logic store);
    if (store) return fmt inside {FMT_B, FMT_H, FMT_W};
    return fmt inside {FMT_B, FMT_H, FMT_W, FMT_BU, FMT_HU};
  endfunction

endpackage

// File: rtl/data_mem_bridge_load_aligner.sv
// Extracts the addressed byte/halfword from a bus read word and sign- or
// zero-extends it according to the load format.
module load_aligner
  import mem_bridge_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [2:0]  format,
  input  logic [1:0]  byte_offset,
  output logic [31:0] load_value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    byte_lane  = bus_rdata[7:0];
    half_lane  = byte_offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_value = bus_rdata;
    case (byte_offset)
      2'd1:    byte_lane = bus_rdata[15:8];
      2'd2:    byte_lane = bus_rdata[23:16];
      2'd3:    byte_lane = bus_rdata[31:24];
      default: byte_lane = bus_rdata[7:0];
    endcase
    case (format)
      FMT_B:   load_value = {{24{byte_lane[7]}}, byte_lane};
      FMT_BU:  load_value = {24'h0, byte_lane};
      FMT_H:   load_value = {{16{half_lane[15]}}, half_lane};
      FMT_HU:  load_value = {16'h0, half_lane};
      default: load_value = bus_rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// MEM-stage to req/ack memory bus bridge: word-aligned byte-enabled accesses,
// formatted load return, pipeline stall and fault reporting.
module data_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [2:0]  format,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        access_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t               state;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 fault_q;
  logic [2:0]           fmt_q;
  logic [1:0]           offset_q;

  logic        access;
  logic        is_store;
  logic        legal;
  logic        start;
  logic        timeout_hit;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] load_value;

  assign access   = read_enable | write_enable;
  assign is_store = write_enable;
  assign legal    = is_legal_format(format, is_store) && is_aligned(format, address[1:0]);
  assign start    = (state == IDLE) && access && legal;

  // Gated by reset so an abort mid-access releases the pipeline at once.
  assign busy         = !reset && (start || (state == REQ));
  assign access_fault = !reset && (((state == IDLE) && access && !legal) ||
                                   ((state == DONE) && fault_q));
  assign bus_req      = (state == REQ);

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = write_data;
    if (is_store) begin
      case (format)
        FMT_B: begin
          store_be    = 4'b0001 << address[1:0];
          store_wdata = {4{write_data[7:0]}};
        end
        FMT_H: begin
          store_be    = address[1] ? 4'b1100 : 4'b0011;
          store_wdata = {2{write_data[15:0]}};
        end
        default: begin
          store_be    = 4'b1111;
          store_wdata = write_data;
        end
      endcase
    end
  end

  load_aligner u_load_aligner (
    .bus_rdata   (bus_rdata),
    .format      (fmt_q),
    .byte_offset (offset_q),
    .load_value  (load_value)
  );

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      fault_q   <= 1'b0;
      fmt_q     <= FMT_B;
      offset_q  <= 2'b00;
      read_data <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus_addr  <= {address[31:2], 2'b00};
            bus_be    <= store_be;
            bus_wdata <= store_wdata;
            bus_we    <= is_store;
            fmt_q     <= format;
            offset_q  <= address[1:0];
            state     <= REQ;
          end else if (access) begin
            read_data <= '0;
          end
        end
        REQ: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (bus_ack) begin
            if (!bus_we) read_data <= load_value;
            state <= DONE;
          end else if (timeout_hit) begin
            fault_q   <= 1'b1;
            read_data <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          wait_cnt <= '0;
          fault_q  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: table-driven accesses with a
// scoreboard, plus hand-written reset, stray-ack and timeout sequences.
module tb_data_mem_bridge;
  import mem_bridge_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address, write_data, bus_rdata;
  logic        read_enable, write_enable, bus_ack;
  logic [2:0]  format;
  logic [31:0] read_data, bus_addr, bus_wdata;
  logic        busy, access_fault, bus_req, bus_we;
  logic [3:0]  bus_be;

  logic        to_read_enable, to_write_enable, to_bus_ack;
  logic [31:0] to_read_data, to_bus_addr, to_bus_wdata;
  logic        to_busy, to_access_fault, to_bus_req, to_bus_we;
  logic [3:0]  to_bus_be;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  data_mem_bridge dut (
    .clock(clock), .reset(reset), .address(address), .write_data(write_data),
    .read_enable(read_enable), .write_enable(write_enable), .format(format),
    .read_data(read_data), .busy(busy), .access_fault(access_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  data_mem_bridge #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(3)) dut_to (
    .clock(clock), .reset(reset), .address(address), .write_data(write_data),
    .read_enable(to_read_enable), .write_enable(to_write_enable), .format(format),
    .read_data(to_read_data), .busy(to_busy), .access_fault(to_access_fault),
    .bus_req(to_bus_req), .bus_we(to_bus_we), .bus_addr(to_bus_addr), .bus_be(to_bus_be),
    .bus_wdata(to_bus_wdata), .bus_ack(to_bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    string       name;
    logic        re;
    logic        we;
    logic [2:0]  fmt;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          req_cycles;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    logic        fault;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] rd;
    int          busy_cycles;
    int          req_cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rd_model = 32'h0;
  vec_t        vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    int          busy_n, req_n;
    logic        done, fault_seen, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    e.fault  = v.fault;
    e.we     = v.we;
    e.addr   = {v.addr[31:2], 2'b00};
    e.be     = v.be;
    e.bwdata = v.bwdata;
    if (v.fault) rd_model = 32'h0;
    else if (!v.we) rd_model = v.rd;
    e.rd          = rd_model;
    e.req_cycles  = v.fault ? 0 : v.req_cycles;
    e.busy_cycles = v.fault ? 0 : 1 + v.req_cycles;
    sb.push_back(e);

    @(posedge clock); #1;
    address = v.addr; write_data = v.wd; format = v.fmt;
    read_enable = v.re; write_enable = v.we; bus_rdata = v.rdata; bus_ack = 1'b0;
    busy_n = 0; req_n = 0; done = 1'b0; fault_seen = 1'b0;
    cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; cap_be = '0;

    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (bus_req) begin
        req_n++;
        if (req_n == 1) begin
          cap_we = bus_we; cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata;
        end
        bus_ack = (req_n == v.req_cycles);
      end else begin
        bus_ack = 1'b0;
      end
      if (access_fault) begin
        done = 1'b1; fault_seen = 1'b1;
      end else if (req_n > 0 && !busy && !bus_req) begin
        done = 1'b1;
      end
    end
    check({v.name, ".completed"}, 32'(done), 32'd1);

    e = sb.pop_front();
    check({v.name, ".fault"}, 32'(fault_seen), 32'(e.fault));
    check({v.name, ".busy_cycles"}, busy_n, e.busy_cycles);
    check({v.name, ".req_cycles"}, req_n, e.req_cycles);
    if (!e.fault) begin
      check({v.name, ".bus_we"}, 32'(cap_we), 32'(e.we));
      check({v.name, ".bus_addr"}, cap_addr, e.addr);
      check({v.name, ".bus_be"}, 32'(cap_be), 32'(e.be));
      if (e.we) check({v.name, ".bus_wdata"}, cap_wdata, e.bwdata);
      check({v.name, ".read_data"}, read_data, e.rd);
      @(posedge clock); #1;
      read_enable = 1'b0; write_enable = 1'b0; bus_ack = 1'b0;
    end else begin
      @(posedge clock); #1;
      read_enable = 1'b0; write_enable = 1'b0; bus_ack = 1'b0;
      @(negedge clock);
      check({v.name, ".read_data"}, read_data, e.rd);
    end
  endtask

  initial begin
    int   req_n;
    logic done_t;
    vec_t v_lhu;

    reset = 1'b1;
    address = '0; write_data = '0; bus_rdata = '0; format = FMT_B;
    read_enable = 1'b0; write_enable = 1'b0; bus_ack = 1'b0;
    to_read_enable = 1'b0; to_write_enable = 1'b0; to_bus_ack = 1'b0;

    //            name           re    we    fmt     addr          wd            rdata         req fault be       bwdata        rd
    vecs[0]  = '{"lb_neg",      1'b1, 1'b0, FMT_B,  32'h0000_1003, 32'h0,        32'h80FF_0000, 1, 1'b0, 4'b1111, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{"sh_wait",     1'b0, 1'b1, FMT_H,  32'h0000_2002, 32'h1234_ABCD, 32'h0,        3, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[2]  = '{"lw_misalign", 1'b1, 1'b0, FMT_W,  32'h0000_3001, 32'h0,        32'h0,         1, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[3]  = '{"fmt_011",     1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,         1, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[4]  = '{"lbu_lane1",   1'b1, 1'b0, FMT_BU, 32'h0000_0101, 32'h0,        32'h1122_8344, 2, 1'b0, 4'b1111, 32'h0,        32'h0000_0083};
    vecs[5]  = '{"lh_hi",       1'b1, 1'b0, FMT_H,  32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 1'b0, 4'b1111, 32'h0,        32'hFFFF_8001};
    vecs[6]  = '{"lhu_lo",      1'b1, 1'b0, FMT_HU, 32'h0000_0100, 32'h0,        32'h1234_F00D, 1, 1'b0, 4'b1111, 32'h0,        32'h0000_F00D};
    vecs[7]  = '{"sb_lane1",    1'b0, 1'b1, FMT_B,  32'h0000_0301, 32'h0000_55AB, 32'h0,        2, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[8]  = '{"sw",          1'b0, 1'b1, FMT_W,  32'h0000_0400, 32'hCAFE_F00D, 32'h0,        1, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[9]  = '{"both_is_sb",  1'b1, 1'b1, FMT_B,  32'h0000_0002, 32'h0000_00C3, 32'h0,        1, 1'b0, 4'b0100, 32'hC3C3_C3C3, 32'h0};
    vecs[10] = '{"sh_misalign", 1'b0, 1'b1, FMT_H,  32'h0000_0501, 32'h0,        32'h0,         1, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{"sbu_illegal", 1'b0, 1'b1, FMT_BU, 32'h0000_0000, 32'h0,        32'h0,         1, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{"lw",          1'b1, 1'b0, FMT_W,  32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 1, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF};

    repeat (2) @(negedge clock);
    check("reset.read_data", read_data, 32'h0);
    check("reset.busy", 32'(busy), 32'h0);
    check("reset.bus_req", 32'(bus_req), 32'h0);
    check("reset.bus_addr", bus_addr, 32'h0);
    check("reset.access_fault", 32'(access_fault), 32'h0);
    @(posedge clock); #1 reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Stray ack while idle must not start or complete anything.
    @(posedge clock); #1 bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    @(posedge clock); #1 bus_ack = 1'b0;
    @(negedge clock);
    check("stray_ack.bus_req", 32'(bus_req), 32'h0);
    check("stray_ack.busy", 32'(busy), 32'h0);
    check("stray_ack.read_data", read_data, 32'hDEAD_BEEF);

    // Reset in the middle of a wait-stated load.
    @(posedge clock); #1;
    address = 32'h600; format = FMT_W; read_enable = 1'b1; bus_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_reset.pre_bus_req", 32'(bus_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mid_reset.bus_req", 32'(bus_req), 32'h0);
    check("mid_reset.busy", 32'(busy), 32'h0);
    check("mid_reset.read_data", read_data, 32'h0);
    read_enable = 1'b0;
    rd_model = 32'h0;
    @(posedge clock); #1 reset = 1'b0;
    v_lhu = '{"lhu_after_reset", 1'b1, 1'b0, FMT_HU, 32'h0000_0010, 32'h0, 32'h0000_8001,
              1, 1'b0, 4'b1111, 32'h0, 32'h0000_8001};
    run_vec(v_lhu);

    // Timeout instance: one acked load, then a load that is never acked.
    @(posedge clock); #1;
    address = 32'h700; format = FMT_W; bus_rdata = 32'h1357_9BDF; to_read_enable = 1'b1;
    @(negedge clock);
    @(negedge clock); to_bus_ack = to_bus_req;
    @(negedge clock); to_bus_ack = 1'b0;
    check("to_ok.read_data", to_read_data, 32'h1357_9BDF);
    @(posedge clock); #1 address = 32'h704;
    req_n = 0; done_t = 1'b0;
    for (int c = 0; c < 40 && !done_t; c++) begin
      @(negedge clock);
      if (to_bus_req) req_n++;
      else if (req_n > 0) done_t = 1'b1;
    end
    check("timeout.completed", 32'(done_t), 32'h1);
    check("timeout.req_cycles", req_n, 32'd4);
    check("timeout.access_fault", 32'(to_access_fault), 32'h1);
    check("timeout.busy", 32'(to_busy), 32'h0);
    check("timeout.read_data", to_read_data, 32'h0);
    @(posedge clock); #1 to_read_enable = 1'b0;
    @(negedge clock);
    check("timeout.fault_cleared", 32'(to_access_fault), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
